nf_bypass_dispatch: RTL and testbench

Front-end steering controller for the NF path. Takes one packet+metadata stream and sends each whole packet, with its metadata, to either the NF pipeline or the bypass path. The NF path is credit-limited by an in-flight packet counter that is returned by NF completion pulses. The downstream merge stage recombines the two paths.

---
 rtl/nf_bypass_dispatch_pkg.sv | 15 +
 rtl/nf_credit_cnt.sv | 32 +++
 rtl/nf_bypass_dispatch.sv | 141 ++++++++++++++
 tb/tb_nf_bypass_dispatch.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/nf_bypass_dispatch_pkg.sv
// Shared types for the NF/bypass dispatch front-end: metadata layout,
// dispatcher state encoding and default credit depth.
package nf_bypass_dispatch_pkg;
  localparam int NF_MAX_INFLIGHT_DEFAULT = 64;
  localparam int DATA_W  = 512;
  localparam int EMPTY_W = 6;

  typedef struct packed {
    logic [15:0] flow_id;
    logic [15:0] pkt_len;
    logic [7:0]  src_port;
  } metadata_t;

  typedef enum logic [1:0] {IDLE, FWD_NF, FWD_BYPASS} dispatch_state_t;
endpackage

// File: rtl/nf_credit_cnt.sv
// In-flight packet counter for the NF path: +1 per NF dispatch, -1 per NF
// retirement, saturating at both ends, with a sticky underflow flag.
module nf_credit_cnt #(
  parameter int MAX_INFLIGHT = 64,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             err_underflow
);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count         <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (dec && count == '0) err_underflow <= 1'b1;
      case ({inc, dec})
        2'b10:   if (count != MAX_CNT) count <= count + 1'b1;
        2'b01:   if (count != '0)      count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign full = (count >= MAX_CNT);
endmodule

// File: rtl/nf_bypass_dispatch.sv
// Steers each whole packet (plus metadata) to the credit-limited NF pipeline
// or to the bypass path. Optional counters under NF_DISPATCH_STATS_EN.
module nf_bypass_dispatch
  import nf_bypass_dispatch_pkg::*;
#(
  parameter int MAX_INFLIGHT = NF_MAX_INFLIGHT_DEFAULT,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  in_pkt_data,
  input  logic               in_pkt_valid,
  input  logic               in_pkt_sop,
  input  logic               in_pkt_eop,
  input  logic [EMPTY_W-1:0] in_pkt_empty,
  output logic               in_pkt_ready,
  input  logic               in_meta_valid,
  input  metadata_t          in_meta_data,
  input  logic               in_meta_force_bypass,
  output logic               in_meta_ready,
  output logic [DATA_W-1:0]  nf_pkt_data,
  output logic               nf_pkt_valid,
  output logic               nf_pkt_sop,
  output logic               nf_pkt_eop,
  output logic [EMPTY_W-1:0] nf_pkt_empty,
  input  logic               nf_pkt_almost_full,
  output logic               nf_meta_valid,
  output metadata_t          nf_meta_data,
  input  logic               nf_done,
  output logic [DATA_W-1:0]  bypass_pkt_data,
  output logic               bypass_pkt_valid,
  output logic               bypass_pkt_sop,
  output logic               bypass_pkt_eop,
  output logic [EMPTY_W-1:0] bypass_pkt_empty,
  input  logic               bypass_pkt_almost_full,
  output logic               bypass_meta_valid,
  output metadata_t          bypass_meta_data,
  input  logic               cfg_nf_enable,
  output logic [CNT_W-1:0]   inflight,
  output logic               err_underflow
`ifdef NF_DISPATCH_STATS_EN
  ,
  output logic [31:0]        stat_nf_pkts,
  output logic [31:0]        stat_bypass_pkts,
  output logic [31:0]        stat_forced_pkts
`endif
);
  dispatch_state_t state, state_nxt;
  logic nf_full, nf_ok, byp_ok, sel_nf, meta_acc, flit_acc;

  assign nf_ok  = cfg_nf_enable & ~in_meta_force_bypass & ~nf_full & ~nf_pkt_almost_full;
  assign byp_ok = ~bypass_pkt_almost_full;

  // Route decision only in IDLE; config and backpressure are ignored mid-packet.
  always_comb begin
    state_nxt     = state;
    in_meta_ready = 1'b0;
    in_pkt_ready  = 1'b0;
    sel_nf        = 1'b0;
    case (state)
      IDLE: begin
        if (in_meta_valid && !rst) begin
          if (nf_ok) begin
            in_meta_ready = 1'b1;
            sel_nf        = 1'b1;
            state_nxt     = FWD_NF;
          end else if (byp_ok) begin
            in_meta_ready = 1'b1;
            state_nxt     = FWD_BYPASS;
          end
        end
      end
      FWD_NF, FWD_BYPASS: begin
        in_pkt_ready = 1'b1;
        if (in_pkt_valid && in_pkt_eop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign meta_acc = in_meta_valid & in_meta_ready;
  assign flit_acc = in_pkt_valid & in_pkt_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      nf_meta_valid     <= 1'b0;
      bypass_meta_valid <= 1'b0;
      nf_pkt_valid      <= 1'b0;
      bypass_pkt_valid  <= 1'b0;
    end else begin
      state             <= state_nxt;
      nf_meta_valid     <= meta_acc & sel_nf;
      bypass_meta_valid <= meta_acc & ~sel_nf;
      nf_pkt_valid      <= flit_acc & (state == FWD_NF);
      bypass_pkt_valid  <= flit_acc & (state == FWD_BYPASS);
    end
  end

  // Payload registers need no reset; they are qualified by the valids above.
  always_ff @(posedge clk) begin
    if (meta_acc) begin
      nf_meta_data     <= in_meta_data;
      bypass_meta_data <= in_meta_data;
    end
    if (flit_acc) begin
      nf_pkt_data      <= in_pkt_data;
      nf_pkt_sop       <= in_pkt_sop;
      nf_pkt_eop       <= in_pkt_eop;
      nf_pkt_empty     <= in_pkt_empty;
      bypass_pkt_data  <= in_pkt_data;
      bypass_pkt_sop   <= in_pkt_sop;
      bypass_pkt_eop   <= in_pkt_eop;
      bypass_pkt_empty <= in_pkt_empty;
    end
  end

  nf_credit_cnt #(.MAX_INFLIGHT(MAX_INFLIGHT), .CNT_W(CNT_W)) u_credit (
    .clk           (clk),
    .rst           (rst),
    .inc           (meta_acc & sel_nf),
    .dec           (nf_done),
    .count         (inflight),
    .full          (nf_full),
    .err_underflow (err_underflow)
  );

`ifdef NF_DISPATCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_nf_pkts     <= '0;
      stat_bypass_pkts <= '0;
      stat_forced_pkts <= '0;
    end else if (meta_acc) begin
      if (sel_nf) stat_nf_pkts     <= stat_nf_pkts + 32'd1;
      else        stat_bypass_pkts <= stat_bypass_pkts + 32'd1;
      if (in_meta_force_bypass) stat_forced_pkts <= stat_forced_pkts + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_nf_bypass_dispatch.sv
// Directed bench for nf_bypass_dispatch with a 4-deep NF credit pool.
module tb_nf_bypass_dispatch;
  import nf_bypass_dispatch_pkg::*;

  localparam int MAXI = 4;
  localparam int CW   = $clog2(MAXI + 1);

  logic clk, rst;
  logic [511:0] in_pkt_data;
  logic in_pkt_valid, in_pkt_sop, in_pkt_eop, in_pkt_ready;
  logic [5:0] in_pkt_empty;
  logic in_meta_valid, in_meta_force_bypass, in_meta_ready;
  metadata_t in_meta_data, nf_meta_data, bypass_meta_data;
  logic [511:0] nf_pkt_data, bypass_pkt_data;
  logic nf_pkt_valid, nf_pkt_sop, nf_pkt_eop, nf_pkt_almost_full, nf_meta_valid, nf_done;
  logic bypass_pkt_valid, bypass_pkt_sop, bypass_pkt_eop, bypass_pkt_almost_full, bypass_meta_valid;
  logic [5:0] nf_pkt_empty, bypass_pkt_empty;
  logic cfg_nf_enable, err_underflow;
  logic [CW-1:0] inflight;

  int errors = 0;
  int checks = 0;

  nf_bypass_dispatch #(.MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rst(rst),
    .in_pkt_data(in_pkt_data), .in_pkt_valid(in_pkt_valid), .in_pkt_sop(in_pkt_sop),
    .in_pkt_eop(in_pkt_eop), .in_pkt_empty(in_pkt_empty), .in_pkt_ready(in_pkt_ready),
    .in_meta_valid(in_meta_valid), .in_meta_data(in_meta_data),
    .in_meta_force_bypass(in_meta_force_bypass), .in_meta_ready(in_meta_ready),
    .nf_pkt_data(nf_pkt_data), .nf_pkt_valid(nf_pkt_valid), .nf_pkt_sop(nf_pkt_sop),
    .nf_pkt_eop(nf_pkt_eop), .nf_pkt_empty(nf_pkt_empty), .nf_pkt_almost_full(nf_pkt_almost_full),
    .nf_meta_valid(nf_meta_valid), .nf_meta_data(nf_meta_data), .nf_done(nf_done),
    .bypass_pkt_data(bypass_pkt_data), .bypass_pkt_valid(bypass_pkt_valid),
    .bypass_pkt_sop(bypass_pkt_sop), .bypass_pkt_eop(bypass_pkt_eop),
    .bypass_pkt_empty(bypass_pkt_empty), .bypass_pkt_almost_full(bypass_pkt_almost_full),
    .bypass_meta_valid(bypass_meta_valid), .bypass_meta_data(bypass_meta_data),
    .cfg_nf_enable(cfg_nf_enable), .inflight(inflight), .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] fdata(input logic [7:0] id, input int i);
    return {32{id, 8'(i)}};
  endfunction

  function automatic metadata_t fmeta(input logic [7:0] id);
    return metadata_t'({8'h00, id, 8'h5a, id, id});
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_pkt_valid = 0; in_pkt_sop = 0; in_pkt_eop = 0; in_pkt_empty = 0; in_pkt_data = '0;
    in_meta_valid = 0; in_meta_force_bypass = 0; in_meta_data = '0; nf_done = 0;
    nf_pkt_almost_full = 0; bypass_pkt_almost_full = 0; cfg_nf_enable = 1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  // One packet: meta handshake then n back-to-back flits, checking the chosen port.
  task automatic pkt(input logic fb, input int n, input logic [5:0] emp, input logic exp_nf,
                     input logic [7:0] id, input logic done_now);
    @(negedge clk);
    in_meta_valid = 1; in_meta_force_bypass = fb; in_meta_data = fmeta(id); nf_done = done_now;
    #1 chk("meta_ready", in_meta_ready, 1'b1);
    @(negedge clk);
    in_meta_valid = 0; in_meta_force_bypass = 0; nf_done = 0;
    chk("nf_meta_valid", nf_meta_valid, exp_nf);
    chk("byp_meta_valid", bypass_meta_valid, !exp_nf);
    chk("meta_data", exp_nf ? nf_meta_data : bypass_meta_data, fmeta(id));
    for (int i = 0; i < n; i++) begin
      in_pkt_valid = 1; in_pkt_sop = (i == 0); in_pkt_eop = (i == n - 1);
      in_pkt_empty = (i == n - 1) ? emp : 6'd0; in_pkt_data = fdata(id, i);
      #1 chk("pkt_ready", in_pkt_ready, 1'b1);
      @(negedge clk);
      if (exp_nf) begin
        chk("nf_valid", nf_pkt_valid, 1'b1);
        chk("nf_sop", nf_pkt_sop, i == 0);
        chk("nf_eop", nf_pkt_eop, i == n - 1);
        chk("nf_data", nf_pkt_data, fdata(id, i));
        if (i == n - 1) chk("nf_empty", nf_pkt_empty, emp);
        chk("byp_valid_quiet", bypass_pkt_valid, 1'b0);
      end else begin
        chk("byp_valid", bypass_pkt_valid, 1'b1);
        chk("byp_sop", bypass_pkt_sop, i == 0);
        chk("byp_eop", bypass_pkt_eop, i == n - 1);
        chk("byp_data", bypass_pkt_data, fdata(id, i));
        if (i == n - 1) chk("byp_empty", bypass_pkt_empty, emp);
        chk("nf_valid_quiet", nf_pkt_valid, 1'b0);
      end
      if (i == 0) chk("meta_one_cycle", nf_meta_valid | bypass_meta_valid, 1'b0);
    end
    in_pkt_valid = 0; in_pkt_sop = 0; in_pkt_eop = 0;
    #1 chk("idle_pkt_ready", in_pkt_ready, 1'b0);
  endtask

  initial begin
    do_reset();
    chk("rst_inflight", inflight, 0);
    chk("rst_err", err_underflow, 1'b0);
    chk("rst_pkt_ready", in_pkt_ready, 1'b0);
    chk("rst_meta_ready", in_meta_ready, 1'b0);
    chk("rst_valids", {nf_pkt_valid, nf_meta_valid, bypass_pkt_valid, bypass_meta_valid}, 4'b0);

    // 3-flit NF packet, then forced single-flit bypass packet with empty=5
    pkt(1'b0, 3, 6'd0, 1'b1, 8'h11, 1'b0);
    chk("t1_inflight", inflight, 1);
    pkt(1'b1, 1, 6'd5, 1'b0, 8'h22, 1'b0);
    chk("t2_inflight", inflight, 1);

    // NF disabled routes to bypass
    cfg_nf_enable = 0;
    pkt(1'b0, 2, 6'd3, 1'b0, 8'h33, 1'b0);
    cfg_nf_enable = 1;
    chk("cfg_off_inflight", inflight, 1);

    // Credit exhaustion: 4 NF, then 2 bypass, then one retirement frees a slot
    do_reset();
    for (int p = 0; p < 6; p++) pkt(1'b0, 1, 6'd0, p < 4, 8'(8'h40 + p), 1'b0);
    chk("t3_inflight_full", inflight, 4);
    @(negedge clk); nf_done = 1;
    @(negedge clk); nf_done = 0;
    chk("t3_after_done", inflight, 3);
    pkt(1'b0, 2, 6'd1, 1'b1, 8'h50, 1'b0);
    chk("t3_refill", inflight, 4);

    // Simultaneous dispatch and retirement at inflight=2
    do_reset();
    pkt(1'b0, 1, 6'd0, 1'b1, 8'h60, 1'b0);
    pkt(1'b0, 1, 6'd0, 1'b1, 8'h61, 1'b0);
    chk("t4_pre", inflight, 2);
    pkt(1'b0, 1, 6'd0, 1'b1, 8'h62, 1'b1);
    chk("t4_same_cycle", inflight, 2);
    chk("t4_no_err", err_underflow, 1'b0);

    // Underflow
    do_reset();
    @(negedge clk); nf_done = 1;
    @(negedge clk); nf_done = 0;
    chk("uf_inflight", inflight, 0);
    chk("uf_err", err_underflow, 1'b1);
    @(negedge clk);
    chk("uf_sticky", err_underflow, 1'b1);

    // Both sinks full: meta held; releasing bypass lets it go there
    do_reset();
    @(negedge clk);
    nf_pkt_almost_full = 1; bypass_pkt_almost_full = 1;
    in_meta_valid = 1; in_meta_data = fmeta(8'h70);
    #1 chk("both_full_ready", in_meta_ready, 1'b0);
    @(negedge clk);
    chk("both_full_hold", in_meta_ready, 1'b0);
    chk("both_full_no_meta", nf_meta_valid | bypass_meta_valid, 1'b0);
    bypass_pkt_almost_full = 0;
    #1 chk("byp_release_ready", in_meta_ready, 1'b1);
    in_meta_valid = 0;
    pkt(1'b0, 2, 6'd7, 1'b0, 8'h71, 1'b0);
    nf_pkt_almost_full = 0;
    chk("t5_inflight", inflight, 0);

    // Reset on the 2nd flit of a 4-flit NF packet
    @(negedge clk);
    in_meta_valid = 1; in_meta_data = fmeta(8'h80);
    @(negedge clk);
    in_meta_valid = 0;
    in_pkt_valid = 1; in_pkt_sop = 1; in_pkt_data = fdata(8'h80, 0);
    @(negedge clk);
    in_pkt_sop = 0; in_pkt_data = fdata(8'h80, 1);
    chk("mid_pre_valid", nf_pkt_valid, 1'b1);
    chk("mid_pre_inflight", inflight, 1);
    rst = 1;
    #1;
    chk("mid_rst_valid", nf_pkt_valid, 1'b0);
    chk("mid_rst_inflight", inflight, 0);
    chk("mid_rst_ready", in_pkt_ready, 1'b0);
    @(negedge clk);
    in_pkt_valid = 0;
    rst = 0;
    pkt(1'b0, 2, 6'd2, 1'b1, 8'h90, 1'b0);
    chk("post_rst_inflight", inflight, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
